// File: rtl/hit_detector_pkg.sv
// Shared definitions for the collision engine and the game-control FSM:
// game_state codes, scan state encoding and bullet owner values.
package stg_pkg;

    typedef enum logic [3:0] {
        INITIAL   = 4'd0,
        START     = 4'd1,
        PLAY      = 4'd2,
        BOMB      = 4'd6,
        SUCCESS   = 4'd8,
        GAMEOVER  = 4'd9,
        COLLISION = 4'd10
    } game_state_e;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        REPORT
    } scan_state_e;

    localparam logic OWNER_ENEMY  = 1'b0;
    localparam logic OWNER_PLAYER = 1'b1;

endpackage

// File: rtl/hit_detector_if.sv
// Bullet table port: synchronous read (1-cycle latency) plus a slot-clear write.
interface hit_detector_if #(
    parameter int ADDR_W  = 5,
    parameter int COORD_W = 10
);
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_data_valid;
    logic               rd_data_owner;
    logic [COORD_W-1:0] rd_data_x;
    logic [COORD_W-1:0] rd_data_y;
    logic               clr_en;
    logic [ADDR_W-1:0]  clr_addr;

    modport master (
        output rd_addr, clr_en, clr_addr,
        input  rd_data_valid, rd_data_owner, rd_data_x, rd_data_y
    );

    modport slave (
        input  rd_addr, clr_en, clr_addr,
        output rd_data_valid, rd_data_owner, rd_data_x, rd_data_y
    );
endinterface

// File: rtl/hit_detector_box_hit.sv
// Square hitbox test: point (p_x,p_y) lies within +/-R of centre (c_x,c_y), edges inclusive.
module box_hit #(
    parameter int COORD_W = 10,
    parameter int R       = 4
) (
    input  logic [COORD_W-1:0] c_x,
    input  logic [COORD_W-1:0] c_y,
    input  logic [COORD_W-1:0] p_x,
    input  logic [COORD_W-1:0] p_y,
    output logic               hit
);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;

    // Larger minus smaller keeps the distance unsigned with no wrap.
    always_comb begin
        dx  = (p_x >= c_x) ? (p_x - c_x) : (c_x - p_x);
        dy  = (p_y >= c_y) ? (p_y - c_y) : (c_y - p_y);
        hit = (dx <= COORD_W'(R)) && (dy <= COORD_W'(R));
    end
endmodule

// File: rtl/hit_detector.sv
// Per-frame collision engine: scans the bullet table once per frame_tick, clears
// consumed bullets, reports a player collision pulse and tracks boss HP.
module hit_detector
    import stg_pkg::*;
#(
    parameter int N_SLOTS  = 32,
    parameter int COORD_W  = 10,
    parameter int PLAYER_R = 4,
    parameter int BOSS_R   = 24,
    parameter int BOSS_HP  = 200,
    parameter int HP_W     = 8
) (
    input  logic               clk,
    input  logic               hard_reset,
    input  logic               frame_tick,
    input  logic               game_en,
    input  logic               game_reset,
    input  logic [3:0]         game_state,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic [COORD_W-1:0] boss_x,
    input  logic [COORD_W-1:0] boss_y,
    hit_detector_if.master     bus,
    output logic               collision,
    output logic               die,
    output logic [HP_W-1:0]    boss_hp,
    output logic               scan_busy,
    output logic               overrun
);
    localparam int ADDR_W = $clog2(N_SLOTS);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              hit_flag_q, hit_flag_d;
    logic [HP_W-1:0]   boss_hp_q, boss_hp_d;
    logic              die_q, die_d;
    logic              overrun_q, overrun_d;

    logic              player_box_hit;
    logic              boss_box_hit;
    logic              eval_active;
    logic [ADDR_W-1:0] eval_slot;
    logic              slot_live;
    logic              enemy_hit;
    logic              player_hit;

    box_hit #(.COORD_W(COORD_W), .R(PLAYER_R)) u_player_box (
        .c_x (player_x),
        .c_y (player_y),
        .p_x (bus.rd_data_x),
        .p_y (bus.rd_data_y),
        .hit (player_box_hit)
    );

    box_hit #(.COORD_W(COORD_W), .R(BOSS_R)) u_boss_box (
        .c_x (boss_x),
        .c_y (boss_y),
        .p_x (bus.rd_data_x),
        .p_y (bus.rd_data_y),
        .hit (boss_box_hit)
    );

    // Read data lags the address by one cycle; DRAIN holds the last address.
    always_comb begin
        eval_active = ((state_q == SCAN) && (rd_addr_q != '0)) || (state_q == DRAIN);
        eval_slot   = (state_q == DRAIN) ? rd_addr_q : (rd_addr_q - ADDR_W'(1));
        slot_live   = eval_active && bus.rd_data_valid && game_en && !game_reset;
        enemy_hit   = slot_live && (bus.rd_data_owner == OWNER_ENEMY)  && player_box_hit;
        player_hit  = slot_live && (bus.rd_data_owner == OWNER_PLAYER) && boss_box_hit;
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        hit_flag_d = hit_flag_q;
        boss_hp_d  = boss_hp_q;
        die_d      = die_q || (boss_hp_q == '0);
        overrun_d  = overrun_q || (frame_tick && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d    = SCAN;
                    rd_addr_d  = '0;
                    hit_flag_d = 1'b0;
                end
            end
            SCAN: begin
                if (rd_addr_q == ADDR_W'(N_SLOTS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            DRAIN:  state_d = REPORT;
            REPORT: begin
                state_d   = IDLE;
                rd_addr_d = '0;
            end
            default: state_d = IDLE;
        endcase

        if (enemy_hit && (game_state != BOMB)) begin
            hit_flag_d = 1'b1;
        end
        if (player_hit && (boss_hp_q != '0)) begin
            boss_hp_d = boss_hp_q - HP_W'(1);
        end

        // Soft reset wins over everything except the sticky overrun flag.
        if (game_reset) begin
            state_d    = IDLE;
            rd_addr_d  = '0;
            hit_flag_d = 1'b0;
            boss_hp_d  = HP_W'(BOSS_HP);
            die_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            hit_flag_q <= 1'b0;
            boss_hp_q  <= HP_W'(BOSS_HP);
            die_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            hit_flag_q <= hit_flag_d;
            boss_hp_q  <= boss_hp_d;
            die_q      <= die_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.rd_addr  = rd_addr_q;
    assign bus.clr_en   = enemy_hit || player_hit;
    assign bus.clr_addr = eval_slot;
    assign collision    = (state_q == REPORT) && hit_flag_q && !game_reset;
    assign scan_busy    = (state_q == SCAN) || (state_q == DRAIN);
    assign die          = die_q;
    assign boss_hp      = boss_hp_q;
    assign overrun      = overrun_q;
endmodule

// File: doc/hit_detector.md
Name: hit_detector

Overview:
- Per-frame collision engine sitting directly upstream of the game-control FSM; generates its `collision` pulse and `die` level.
- Once per frame, scans the shared bullet table (synchronous RAM, 1-cycle read latency):
  - enemy bullets are tested against the player hitbox;
  - player bullets are tested against the boss hitbox.
- Clears consumed bullet slots through a write port and tracks boss HP.

Parameters:
- N_SLOTS, 32, bullet table depth (power of 2).
- COORD_W, 10, coordinate width (unsigned pixels).
- PLAYER_R, 4, player hit half-width (square box).
- BOSS_R, 24, boss hit half-width (square box).
- BOSS_HP, 200, boss hit points loaded on reset/game_reset.
- HP_W, 8, HP counter width.

Ports:
- clk  in  1  system clock
- hard_reset  in  1  async active-high reset
- frame_tick  in  1  one-cycle pulse, start of frame scan
- game_en  in  1  from FSM; gates all hit processing
- game_reset  in  1  from FSM; synchronous soft reset of HP/scan
- game_state  in  4  from FSM; BOMB code suppresses player damage
- player_x, player_y  in  COORD_W each  player centre
- boss_x, boss_y  in  COORD_W each  boss centre
- rd_addr  out  log2(N_SLOTS)  bullet table read address
- rd_data_valid  in  1  slot occupied (data for address issued previous cycle)
- rd_data_owner  in  1  0 = enemy bullet, 1 = player bullet
- rd_data_x, rd_data_y  in  COORD_W each  bullet centre
- clr_en  out  1  clear (free) slot clr_addr this cycle
- clr_addr  out  log2(N_SLOTS)  slot to clear
- collision  out  1  one-cycle pulse: player hit this frame
- die  out  1  level: boss HP reached 0
- boss_hp  out  HP_W  current boss HP
- scan_busy  out  1  scan in progress
- overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Reset: hard_reset is asynchronous, active-high; clock clk. On assertion:
  - state=IDLE; rd_addr=0; clr_en=0; collision=0; die=0; scan_busy=0; overrun=0; boss_hp=BOSS_HP.
- game_reset (synchronous, highest priority after hard_reset):
  - same values as hard_reset, except overrun is kept;
  - aborts any scan in progress; no clr_en or collision is issued that cycle.
- States:
  - IDLE: on frame_tick → SCAN, rd_addr=0, scan_busy=1, hit_flag=0.
  - SCAN: rd_addr increments every cycle. Data returned for address a-1 is evaluated in the cycle rd_addr=a. After issuing N_SLOTS-1 → DRAIN.
  - DRAIN: evaluates the last slot → REPORT.
  - REPORT: collision=hit_flag for exactly this cycle; scan_busy=0 → IDLE.
  - Scan length: N_SLOTS+2 cycles from frame_tick to REPORT inclusive.
- Hit test: |bx-px|<=R and |by-py|<=R.
  - Absolute difference computed as an unsigned COORD_W compare (larger minus smaller); no signed wrap.
  - Edge equality counts as a hit.
- Per evaluated slot, only when rd_data_valid=1 and game_en=1:
  - Enemy bullet inside the player box:
    - clr_en=1, clr_addr=slot;
    - if game_state != BOMB, set hit_flag;
    - in BOMB, the bullet is cleared with no damage.
  - Player bullet inside the boss box:
    - clr_en=1, clr_addr=slot;
    - if boss_hp>0, boss_hp decrements by 1 (saturating at 0).
  - Otherwise clr_en=0.
- Multiple enemy hits in one frame produce a single collision pulse.
- game_en=0: the scan still runs, but there are no clears, no HP change and no collision.
- die:
  - combinational (boss_hp==0), registered, so die rises the cycle after the last HP decrement;
  - held until hard_reset or game_reset.
- frame_tick while not IDLE: ignored; overrun set to 1; cleared only by hard_reset.
- Simultaneous frame_tick and REPORT: the tick is treated as busy (overrun), not queued.

Decomposition:
- Package stg_pkg:
  - game_state codes (INITIAL=0, START=1, PLAY=2, BOMB=6, SUCCESS=8, GAMEOVER=9, COLLISION=10), shared with the FSM;
  - scan state enum;
  - OWNER_ENEMY/OWNER_PLAYER constants.
- Sub-module box_hit (combinational): centre pair + radius → hit. Instantiated twice (player box, boss box).

Test Plan:
1. One enemy bullet at slot 5, exactly (px+4, py-4), game_en=1, state PLAY, frame_tick → clr_en with clr_addr=5 during evaluation; a single collision pulse at cycle N_SLOTS+2 (cycle 34).
2. Three enemy hits in one frame → exactly one collision pulse. Same setup with a bullet at px+5 → no hit, no clear.
3. Same enemy hit with game_state=6 (BOMB) → slot cleared, collision stays 0.
4. BOSS_HP=2, two player bullets in the boss box → boss_hp goes 2→1→0; die=1 one cycle after it reaches 0. A third hit next frame → boss_hp stays 0.
5. frame_tick at cycle 10 of a scan → overrun=1; the scan completes normally; the next tick after IDLE scans normally.
6. game_reset mid-scan (cycle 15) with boss_hp=50 → next cycle state IDLE, boss_hp=BOSS_HP, die=0, no collision pulse. hard_reset async mid-cycle → all outputs at reset values immediately.
